// File: rtl/booth_rb_sequencer.sv
// Radix-2 Booth multiply sequencer: reads two operands from a register bank,
// runs 32 Booth steps, then writes the 64-bit product back as one or two words.
module booth_rb_sequencer #(
   parameter int HI_WRITE = 1
) (
   input  logic        clk,
   input  logic        reset_all,
   input  logic        start,
   input  logic [3:0]  rs_sel,
   input  logic [3:0]  rt_sel,
   input  logic [3:0]  rd_sel,
   input  logic [31:0] out1,
   input  logic [31:0] out2,
   output logic [3:0]  rs,
   output logic [3:0]  rt,
   output logic [3:0]  rd,
   output logic        read,
   output logic        write,
   output logic        enable,
   output logic [31:0] in1,
   output logic        busy,
   output logic        done,
   output logic [63:0] prod
);

   typedef enum logic [2:0] {IDLE, READ, RUN, WR_LO, WR_HI, DONE} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  rs_reg, rt_reg, rd_reg, rd_lat_reg;
   logic [32:0] a_reg;
   logic [31:0] m_reg, q_reg;
   logic        q1_reg;
   logic [4:0]  count_reg;
   logic [63:0] prod_reg;
   logic [31:0] in1_reg;

   logic [32:0] m_ext, sum, a_next;
   logic [31:0] q_next;
   logic [63:0] prod_next;

   // One Booth step; A carries a guard bit so subtracting M = -2^31 stays exact.
   always_comb begin
      m_ext = {m_reg[31], m_reg};
      case ({q_reg[0], q1_reg})
         2'b01:   sum = a_reg + m_ext;
         2'b10:   sum = a_reg - m_ext;
         default: sum = a_reg;
      endcase
      a_next    = {sum[32], sum[32:1]};
      q_next    = {sum[0], q_reg[31:1]};
      prod_next = {a_next[31:0], q_next};
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = READ;
         READ:    state_next = RUN;
         RUN:     if (count_reg == 5'd31) state_next = WR_LO;
         WR_LO:   state_next = (HI_WRITE != 0) ? WR_HI : DONE;
         WR_HI:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      read   = (state_reg == READ);
      write  = (state_reg == WR_LO) || (state_reg == WR_HI);
      enable = read || write;
      busy   = (state_reg != IDLE);
      done   = (state_reg == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset_all) begin
         state_reg  <= IDLE;
         rs_reg     <= '0;
         rt_reg     <= '0;
         rd_reg     <= '0;
         rd_lat_reg <= '0;
         a_reg      <= '0;
         m_reg      <= '0;
         q_reg      <= '0;
         q1_reg     <= 1'b0;
         count_reg  <= '0;
         prod_reg   <= '0;
         in1_reg    <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rs_reg     <= rs_sel;
                  rt_reg     <= rt_sel;
                  rd_lat_reg <= rd_sel;
               end
            end
            READ: begin
               m_reg     <= out1;
               q_reg     <= out2;
               a_reg     <= '0;
               q1_reg    <= 1'b0;
               count_reg <= '0;
            end
            RUN: begin
               a_reg     <= a_next;
               q_reg     <= q_next;
               q1_reg    <= q_reg[0];
               count_reg <= count_reg + 5'd1;
               // Last step: present the low word so WR_LO can strobe immediately.
               if (count_reg == 5'd31) begin
                  prod_reg <= prod_next;
                  rd_reg   <= rd_lat_reg;
                  in1_reg  <= prod_next[31:0];
               end
            end
            WR_LO: begin
               if (HI_WRITE != 0) begin
                  rd_reg  <= rd_lat_reg + 4'd1;
                  in1_reg <= prod_reg[63:32];
               end
            end
            default: ;
         endcase
      end
   end

   assign rs   = rs_reg;
   assign rt   = rt_reg;
   assign rd   = rd_reg;
   assign in1  = in1_reg;
   assign prod = prod_reg;

endmodule

// File: tb/tb_booth_rb_sequencer.sv
// Directed and randomised checks of booth_rb_sequencer against a behavioural
// register bank, for both the two-word and the low-word-only variants.
module tb_booth_rb_sequencer;

   logic        clk = 1'b0;
   logic        reset_all = 1'b0;

   logic        start = 1'b0, start_b = 1'b0;
   logic [3:0]  rs_sel = '0, rt_sel = '0, rd_sel = '0;
   logic [3:0]  rs_sel_b = '0, rt_sel_b = '0, rd_sel_b = '0;
   logic [31:0] out1, out2, out1_b, out2_b;
   logic [3:0]  rs, rt, rd, rs_b, rt_b, rd_b;
   logic        read, write, enable, busy, done;
   logic        read_b, write_b, enable_b, busy_b, done_b;
   logic [31:0] in1, in1_b;
   logic [63:0] prod, prod_b;

   logic [31:0] bank [16];
   logic [31:0] bank_b [16];

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int wr_seen = 0;
   int done_seen = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   booth_rb_sequencer #(.HI_WRITE(1)) u_dut (
      .clk(clk), .reset_all(reset_all), .start(start),
      .rs_sel(rs_sel), .rt_sel(rt_sel), .rd_sel(rd_sel),
      .out1(out1), .out2(out2), .rs(rs), .rt(rt), .rd(rd),
      .read(read), .write(write), .enable(enable), .in1(in1),
      .busy(busy), .done(done), .prod(prod)
   );

   booth_rb_sequencer #(.HI_WRITE(0)) u_dut_lo (
      .clk(clk), .reset_all(reset_all), .start(start_b),
      .rs_sel(rs_sel_b), .rt_sel(rt_sel_b), .rd_sel(rd_sel_b),
      .out1(out1_b), .out2(out2_b), .rs(rs_b), .rt(rt_b), .rd(rd_b),
      .read(read_b), .write(write_b), .enable(enable_b), .in1(in1_b),
      .busy(busy_b), .done(done_b), .prod(prod_b)
   );

   // Register banks: combinational read, write on the rising edge.
   assign out1   = bank[rs];
   assign out2   = bank[rt];
   assign out1_b = bank_b[rs_b];
   assign out2_b = bank_b[rt_b];

   always @(posedge clk) begin
      if (write && enable) bank[rd] = in1;
      if (write_b && enable_b) bank_b[rd_b] = in1_b;
   end

   // Strobe-exclusivity monitor, every cycle on both instances.
   always @(negedge clk) begin
      checks++;
      assert (!(read && write) && !(read_b && write_b)) else begin
         errors++;
         $error("FAIL strobe_excl observed read=%b write=%b read_b=%b write_b=%b required no overlap",
                read, write, read_b, write_b);
      end
      if (write) wr_seen++;
      if (done) done_seen++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete operation on the two-word instance, checked end to end.
   task automatic run_op(input string tag, input logic [3:0] s, input logic [3:0] t,
                         input logic [3:0] d, input logic [31:0] va, input logic [31:0] vb,
                         input logic [63:0] expp);
      int e0;
      int n;
      logic [3:0] d1;
      d1 = d + 4'd1;
      bank[s] = va;
      bank[t] = vb;
      rs_sel = s; rt_sel = t; rd_sel = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = edge_cnt;
      check({tag, "_read"}, {read, enable, rs, rt}, {1'b1, 1'b1, s, t});
      rs_sel = ~s; rt_sel = ~t; rd_sel = ~d;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 64'(edge_cnt - e0), 64'd35);
      @(negedge clk);
      check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
      check({tag, "_prod"}, prod, expp);
      check({tag, "_rd_lo"}, 64'(bank[d]), 64'(expp[31:0]));
      check({tag, "_rd_hi"}, 64'(bank[d1]), 64'(expp[63:32]));
   endtask

   initial begin
      int e0;
      int n;
      logic [3:0] s, t, d;
      logic [31:0] va, vb;
      longint pe;

      for (int i = 0; i < 16; i++) begin
         bank[i] = 32'd0;
         bank_b[i] = 32'd0;
      end

      // Reset dominates a simultaneous start.
      reset_all = 1'b1;
      start = 1'b1;
      start_b = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_strobes", {60'd0, busy, done, read, write}, 64'd0);
      check("reset_enable", {63'd0, enable}, 64'd0);
      check("reset_prod", prod, 64'd0);
      check("reset_idx_in1", {rs, rt, rd, in1}, 64'd0);
      check("reset_lo_busy", {63'd0, busy_b}, 64'd0);
      reset_all = 1'b0;
      start = 1'b0;
      start_b = 1'b0;
      @(negedge clk);
      check("idle_busy", {62'd0, busy, enable}, 64'd0);

      run_op("small", 4'd1, 4'd2, 4'd4, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("minsq", 4'd1, 4'd2, 4'd4, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("wrap", 4'd1, 4'd2, 4'd15, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
      check("wrap_r0", 64'(bank[0]), 64'hFFFF_FFFF);
      run_op("square_rd", 4'd3, 4'd3, 4'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 64'd25);
      run_op("minxpos", 4'd8, 4'd9, 4'd10, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
      run_op("zero", 4'd5, 4'd6, 4'd12, 32'd0, 32'h1234_5678, 64'd0);

      // Low-word-only instance.
      bank_b[1] = 32'h0001_0000;
      bank_b[2] = 32'h0001_0000;
      bank_b[6] = 32'h1234_5678;
      bank_b[7] = 32'hA5A5_A5A5;
      rs_sel_b = 4'd1; rt_sel_b = 4'd2; rd_sel_b = 4'd6;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      e0 = edge_cnt;
      n = 0;
      while (!done_b && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("lo_latency", 64'(edge_cnt - e0), 64'd34);
      @(negedge clk);
      check("lo_busy_low", {63'd0, busy_b}, 64'd0);
      check("lo_prod", prod_b, 64'h0000_0001_0000_0000);
      check("lo_r6", 64'(bank_b[6]), 64'd0);
      check("lo_r7", 64'(bank_b[7]), 64'hA5A5_A5A5);

      // Start mid-run is ignored; reset at count 20 aborts without writing.
      bank[1] = 32'd11;
      bank[2] = 32'd13;
      bank[9] = 32'h5A5A_5A5A;
      bank[10] = 32'h0BAD_F00D;
      rs_sel = 4'd1; rt_sel = 4'd2; rd_sel = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = edge_cnt;
      wr_seen = 0;
      done_seen = 0;
      while (edge_cnt - e0 < 11) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (edge_cnt - e0 < 21) @(negedge clk);
      check("abort_busy_before", {63'd0, busy}, 64'd1);
      reset_all = 1'b1;
      @(negedge clk);
      reset_all = 1'b0;
      check("abort_busy_after", {63'd0, busy}, 64'd0);
      repeat (45) @(negedge clk);
      check("abort_no_write", 64'(wr_seen), 64'd0);
      check("abort_no_done", 64'(done_seen), 64'd0);
      check("abort_still_idle", {63'd0, busy}, 64'd0);
      check("abort_r9", 64'(bank[9]), 64'h5A5A_5A5A);
      check("abort_r10", 64'(bank[10]), 64'h0BAD_F00D);

      // Random signed operands against a 64-bit multiply.
      for (int k = 0; k < 200; k++) begin
         s = 4'($urandom_range(0, 15));
         t = 4'($urandom_range(0, 15));
         d = 4'($urandom_range(0, 15));
         va = $urandom;
         vb = $urandom;
         if (k % 10 == 0) va = 32'h8000_0000;
         if (k % 7 == 0) vb = 32'hFFFF_FFFF;
         if (s == t) vb = va;
         pe = longint'(int'(va)) * longint'(int'(vb));
         run_op($sformatf("rand%0d", k), s, t, d, va, vb, 64'(pe));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
